// File: rtl/solution_count_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : solution_count_accumulator
// Purpose  : Captures one final solution count per N-Queens worker channel and
//            serially sums them, with saturation, into a held board total.
// Revision : 1.0 - initial release
// ============================================================================
module solution_count_accumulator #(
    parameter int NUM_CH = 8,
    parameter int IN_W   = 24,
    parameter int CNT_W  = 24,
    parameter int IDX_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*IN_W-1:0]   ch_count,
    output logic [NUM_CH-1:0]        ch_ready,
    output logic [CNT_W-1:0]         total,
    output logic                     total_valid,
    output logic                     overflow,
    output logic                     busy,
    output logic [NUM_CH-1:0]        done_mask
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_SUM     = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [NUM_CH-1:0] c_all_done = {NUM_CH{1'b1}};
    localparam logic [CNT_W-1:0]  c_max      = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0]  c_last_idx = IDX_W'(NUM_CH - 1);

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [IDX_W-1:0]       r_idx;
    logic [CNT_W-1:0]       r_total;
    logic                   r_overflow;
    logic [NUM_CH-1:0]      r_done_mask;
    logic [NUM_CH-1:0]      r_ch_ready;
    logic [NUM_CH-1:0]      w_capture;
    logic [NUM_CH-1:0]      w_done_mask_next;
    logic [NUM_CH*IN_W-1:0] w_cnt_flat;
    logic [CNT_W-1:0]       w_addend;
    logic [CNT_W:0]         w_sum;

    // r_ch_ready is only non-zero in COLLECT, so it alone qualifies a capture
    assign w_capture        = ch_valid & r_ch_ready;
    assign w_done_mask_next = r_done_mask | w_capture;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [IN_W-1:0] r_cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (!start && w_capture[i]) begin
                    r_cnt <= ch_count[i*IN_W +: IN_W];
                end
            end
            assign w_cnt_flat[i*IN_W +: IN_W] = r_cnt;
        end
    endgenerate

    always_comb begin
        w_addend            = '0;
        w_addend[IN_W-1:0]  = w_cnt_flat[r_idx*IN_W +: IN_W];
        w_sum               = {1'b0, r_total} + {1'b0, w_addend};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = S_COLLECT;
        end else begin
            case (r_state)
                S_COLLECT: if (r_done_mask == c_all_done) w_state_next = S_SUM;
                S_SUM:     if (r_idx == c_last_idx)       w_state_next = S_DONE;
                default:   w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_total     <= '0;
            r_overflow  <= 1'b0;
            r_done_mask <= '0;
            r_ch_ready  <= '0;
        end else if (start) begin
            r_idx       <= '0;
            r_total     <= '0;
            r_overflow  <= 1'b0;
            r_done_mask <= '0;
            r_ch_ready  <= c_all_done;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    r_idx       <= '0;
                    r_done_mask <= w_done_mask_next;
                    r_ch_ready  <= ~w_done_mask_next;
                end
                S_SUM: begin
                    r_ch_ready <= '0;
                    r_idx      <= r_idx + 1'b1;
                    // carry out of the widened add means the total saturates
                    if (w_sum[CNT_W]) begin
                        r_total    <= c_max;
                        r_overflow <= 1'b1;
                    end else begin
                        r_total    <= w_sum[CNT_W-1:0];
                    end
                end
                default: r_ch_ready <= '0;
            endcase
        end
    end

    assign ch_ready    = r_ch_ready;
    assign total       = r_total;
    assign total_valid = (r_state == S_DONE);
    assign overflow    = r_overflow;
    assign busy        = (r_state == S_COLLECT) || (r_state == S_SUM);
    assign done_mask   = r_done_mask;

endmodule
`default_nettype wire

// File: tb/tb_solution_count_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_solution_count_accumulator
// Purpose  : Scoreboard bench for solution_count_accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_solution_count_accumulator;

    localparam int NUM_CH = 8;
    localparam int IN_W   = 24;
    localparam int CNT_W  = 24;
    localparam int IDX_W  = 3;

    logic                   clk;
    logic                   rst_n;
    logic                   start;
    logic [NUM_CH-1:0]      ch_valid;
    logic [NUM_CH*IN_W-1:0] ch_count;
    logic [NUM_CH-1:0]      ch_ready;
    logic [CNT_W-1:0]       total;
    logic                   total_valid;
    logic                   overflow;
    logic                   busy;
    logic [NUM_CH-1:0]      done_mask;

    int n_err = 0;
    int n_chk = 0;

    // each entry is {overflow, total}
    logic [CNT_W:0] sb_q [$];
    logic [IN_W-1:0] vals [NUM_CH];

    solution_count_accumulator #(
        .NUM_CH(NUM_CH), .IN_W(IN_W), .CNT_W(CNT_W), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ch_valid(ch_valid), .ch_count(ch_count), .ch_ready(ch_ready),
        .total(total), .total_valid(total_valid), .overflow(overflow),
        .busy(busy), .done_mask(done_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [IN_W-1:0] v);
        ch_count[i*IN_W +: IN_W] = v;
    endtask

    // Reference: sequential add with saturation at CNT_W bits
    task automatic push_expected();
        logic [CNT_W:0] acc;
        logic           ovf;
        acc = '0;
        ovf = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            acc = {1'b0, acc[CNT_W-1:0]} + (CNT_W+1)'(vals[i]);
            if (acc[CNT_W]) begin
                acc = {1'b0, {CNT_W{1'b1}}};
                ovf = 1'b1;
            end
        end
        sb_q.push_back({ovf, acc[CNT_W-1:0]});
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_result(input int exp_lat);
        int n;
        logic [CNT_W:0] e;
        n = 0;
        while (!total_valid && n < 100) begin
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'(exp_lat));
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk("total", 64'(total), 64'(e[CNT_W-1:0]));
            chk("overflow", 64'(overflow), 64'(e[CNT_W]));
        end
    endtask

    task automatic capture_all_at_once();
        for (int i = 0; i < NUM_CH; i++) set_ch(i, vals[i]);
        ch_valid = '1;
        tick();
        ch_valid = '0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        ch_valid = '0;
        ch_count = '0;
        #3;
        chk("rst_total", 64'(total), 64'd0);
        chk("rst_total_valid", 64'(total_valid), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_done_mask", 64'(done_mask), 64'd0);
        chk("rst_ch_ready", 64'(ch_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_ch_ready", 64'(ch_ready), 64'd0);

        // Run 1: one channel per cycle
        vals = '{24'd4, 24'd8, 24'd16, 24'd18, 24'd18, 24'd16, 24'd8, 24'd4};
        do_start();
        chk("start_ch_ready", 64'(ch_ready), 64'hFF);
        chk("start_busy", 64'(busy), 64'd1);
        push_expected();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_valid = '0;
            ch_valid[i] = 1'b1;
            set_ch(i, vals[i]);
            tick();
        end
        ch_valid = '0;
        chk("r1_done_mask", 64'(done_mask), 64'hFF);
        chk("r1_ch_ready", 64'(ch_ready), 64'd0);
        wait_result(9);
        chk("r1_total_92", 64'(total), 64'd92);

        // Run 2: all channels in one cycle with random counts
        for (int i = 0; i < NUM_CH; i++) vals[i] = IN_W'($urandom_range(0, 100000));
        do_start();
        chk("r2_total_cleared", 64'(total), 64'd0);
        push_expected();
        capture_all_at_once();
        chk("r2_done_mask", 64'(done_mask), 64'hFF);
        wait_result(9);

        // Run 3: saturation
        vals = '{24'hFFFFF0, 24'h20, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0};
        do_start();
        push_expected();
        capture_all_at_once();
        wait_result(9);
        repeat (3) tick();
        chk("r3_hold_total", 64'(total), 64'hFFFFFF);
        chk("r3_hold_overflow", 64'(overflow), 64'd1);
        chk("r3_hold_valid", 64'(total_valid), 64'd1);
        chk("r3_busy", 64'(busy), 64'd0);

        // Run 4: abort after 3 captures; restart races a handshake
        do_start();
        chk("r4_overflow_cleared", 64'(overflow), 64'd0);
        for (int i = 0; i < 3; i++) begin
            ch_valid = '0;
            ch_valid[i] = 1'b1;
            set_ch(i, 24'd50);
            tick();
        end
        chk("r4_partial_mask", 64'(done_mask), 64'h07);
        ch_valid = 8'h08;
        set_ch(3, 24'd77);
        start = 1'b1;
        tick();
        start = 1'b0;
        ch_valid = '0;
        chk("r4_restart_mask", 64'(done_mask), 64'd0);
        chk("r4_restart_total", 64'(total), 64'd0);
        for (int i = 0; i < NUM_CH; i++) vals[i] = IN_W'(1000 * (i + 1));
        push_expected();
        capture_all_at_once();
        wait_result(9);

        // Run 5: held valid on a captured channel must not re-latch
        vals = '{24'd3, 24'd5, 24'd100, 24'd7, 24'd11, 24'd13, 24'd17, 24'd19};
        do_start();
        push_expected();
        ch_valid = 8'h04;
        set_ch(2, 24'd100);
        tick();
        chk("r5_mask_ch2", 64'(done_mask), 64'h04);
        for (int i = 0; i < NUM_CH; i++) begin
            if (i != 2) begin
                ch_valid = 8'h04;
                ch_valid[i] = 1'b1;
                set_ch(i, vals[i]);
                set_ch(2, IN_W'(999 + i));
                tick();
                chk("r5_ready_ch2", 64'(ch_ready[2]), 64'd0);
            end
        end
        ch_valid = '0;
        wait_result(9);

        // Run 6: asynchronous reset during SUM
        for (int i = 0; i < NUM_CH; i++) vals[i] = IN_W'(i + 1);
        do_start();
        capture_all_at_once();
        tick();
        tick();
        chk("r6_mid_sum_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("r6_async_total", 64'(total), 64'd0);
        chk("r6_async_busy", 64'(busy), 64'd0);
        chk("r6_async_mask", 64'(done_mask), 64'd0);
        chk("r6_async_valid", 64'(total_valid), 64'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("r6_idle_ready", 64'(ch_ready), 64'd0);
        chk("r6_idle_busy", 64'(busy), 64'd0);
        chk("r6_sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
